// File: rtl/md_scheduler.sv
// Multiply/divide sequencer for the MIPS E stage: owns HI/LO, runs mult/div over
// fixed latencies, serves mthi/mtlo/mf reads and raises the D-stage stall.
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  E_MDU_op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        E_mf_lo,
  input  logic        E_flush,
  input  logic        D_md_use,
  output logic        start,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] mf_data
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] phi_q, phi_d, plo_q, plo_d;

  logic        is_md_s;
  logic        start_s;
  logic [63:0] prod_s_s;
  logic [63:0] prod_u_s;
  logic [31:0] a_mag_s, b_mag_s, b_mag_nz_s, b_u_nz_s;
  logic [31:0] uq_s, ur_s, sq_s, sr_s, dq_s, dr_s;

  assign is_md_s = (E_MDU_op >= OP_MULT) && (E_MDU_op <= OP_DIVU);
  assign start_s = (state_q == ST_IDLE) && is_md_s && !E_flush;

  assign prod_s_s = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
  assign prod_u_s = {32'd0, E_A} * {32'd0, E_B};

  // Signed divide via magnitudes; 0x80000000 / -1 wraps back to 0x80000000 with remainder 0.
  assign a_mag_s    = E_A[31] ? (~E_A + 32'd1) : E_A;
  assign b_mag_s    = E_B[31] ? (~E_B + 32'd1) : E_B;
  assign b_mag_nz_s = (E_B == 32'd0) ? 32'd1 : b_mag_s;
  assign b_u_nz_s   = (E_B == 32'd0) ? 32'd1 : E_B;
  assign uq_s       = a_mag_s / b_mag_nz_s;
  assign ur_s       = a_mag_s % b_mag_nz_s;
  assign sq_s       = (E_A[31] ^ E_B[31]) ? (~uq_s + 32'd1) : uq_s;
  assign sr_s       = E_A[31] ? (~ur_s + 32'd1) : ur_s;
  assign dq_s       = E_A / b_u_nz_s;
  assign dr_s       = E_A % b_u_nz_s;

  // Next-state: op acceptance in IDLE, countdown and result commit in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
          cnt_d   = 4'(DIV_CYCLES);
          case (E_MDU_op)
            OP_MULT: begin
              {phi_d, plo_d} = prod_s_s;
              cnt_d          = 4'(MULT_CYCLES);
            end
            OP_MULTU: begin
              {phi_d, plo_d} = prod_u_s;
              cnt_d          = 4'(MULT_CYCLES);
            end
            OP_DIV: begin
              if (E_B == 32'd0) begin
                {phi_d, plo_d} = {hi_q, lo_q};
              end else begin
                {phi_d, plo_d} = {sr_s, sq_s};
              end
            end
            OP_DIVU: begin
              if (E_B == 32'd0) begin
                {phi_d, plo_d} = {hi_q, lo_q};
              end else begin
                {phi_d, plo_d} = {dr_s, dq_s};
              end
            end
            default: begin
              {phi_d, plo_d} = {hi_q, lo_q};
            end
          endcase
        end else if (!E_flush && !busy_q && (E_MDU_op == OP_MTHI)) begin
          hi_d = E_A;
        end else if (!E_flush && !busy_q && (E_MDU_op == OP_MTLO)) begin
          lo_d = E_A;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = phi_q;
          lo_d    = plo_q;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and HI/LO registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
    end
  end

  assign start   = start_s;
  assign busy    = busy_q;
  assign stall   = D_md_use && (start_s || busy_q);
  assign HI      = hi_q;
  assign LO      = lo_q;
  assign mf_data = E_mf_lo ? lo_q : hi_q;

endmodule
